// File: rtl/scariv_l1d_snoop_requester_pkg.sv
// ============================================================================
// Module  : scariv_l1d_snoop_requester_pkg
// Purpose : Shared types for the L1D snoop requester: the LSU s1 status
//           (as seen on the L1D snoop slave), the status returned to the
//           coherence agent, the requester FSM encoding and default widths.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package scariv_l1d_snoop_requester_pkg;

    // Default widths, matching riscv_pkg::PADDR_W / scariv_conf_pkg::DCACHE_DATA_W
    localparam int PADDR_W_DEF       = 56;
    localparam int DCACHE_DATA_W_DEF = 128;

    // L1D s1 response status, unchanged from the LSU
    typedef enum logic [1:0] {
        STATUS_NONE         = 2'd0,
        STATUS_HIT          = 2'd1,
        STATUS_MISS         = 2'd2,
        STATUS_L1D_CONFLICT = 2'd3
    } lsu_status_t;

    // Status reported back to the coherence agent
    typedef enum logic [1:0] {
        SNOOP_HIT        = 2'd0,
        SNOOP_MISS       = 2'd1,
        SNOOP_RETRY_FAIL = 2'd2,
        SNOOP_TIMEOUT    = 2'd3
    } snoop_resp_status_t;

    // Requester FSM
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_S0      = 3'd1,
        ST_S1      = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RESP    = 3'd4
    } snoop_req_state_t;

endpackage

`default_nettype wire

// File: rtl/scariv_l1d_snoop_requester.sv
// ============================================================================
// Module  : scariv_l1d_snoop_requester
// Purpose : Initiator of the LSU L1D snoop read port. Accepts one snoop
//           request at a time, issues an s0 read, collects the s1 status,
//           backs off and retries on L1D conflicts, times out if s1 never
//           answers, and returns status/data/be over a valid/ready channel.
// Ports   : i_clk, i_reset_n             - clock, async active-low reset
//           i_snoop_req_*                - request in (valid/ready, paddr)
//           o_l1d_req_s0_*               - L1D snoop s0 request
//           i_l1d_resp_s1_*              - L1D snoop s1 response
//           o_snoop_resp_* / i_..._ready - response out (valid/ready)
//           o_busy                       - FSM not idle
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module scariv_l1d_snoop_requester
    import scariv_l1d_snoop_requester_pkg::*;
#(
    parameter int PADDR_W    = PADDR_W_DEF,
    parameter int DATA_W     = DCACHE_DATA_W_DEF,
    parameter int RETRY_WAIT = 4,
    parameter int MAX_RETRY  = 8,
    parameter int S1_TIMEOUT = 15
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,

    input  logic                  i_snoop_req_valid,
    output logic                  o_snoop_req_ready,
    input  logic [PADDR_W-1:0]    i_snoop_req_paddr,

    output logic                  o_l1d_req_s0_valid,
    output logic [PADDR_W-1:0]    o_l1d_req_s0_paddr,

    input  logic                  i_l1d_resp_s1_valid,
    input  lsu_status_t           i_l1d_resp_s1_status,
    input  logic [DATA_W-1:0]     i_l1d_resp_s1_data,
    input  logic [DATA_W/8-1:0]   i_l1d_resp_s1_be,

    output logic                  o_snoop_resp_valid,
    input  logic                  i_snoop_resp_ready,
    output snoop_resp_status_t    o_snoop_resp_status,
    output logic [DATA_W-1:0]     o_snoop_resp_data,
    output logic [DATA_W/8-1:0]   o_snoop_resp_be,

    output logic                  o_busy
);

    localparam int BE_W    = DATA_W / 8;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int BO_W    = $clog2(RETRY_WAIT + 1);
    localparam int TO_W    = $clog2(S1_TIMEOUT + 1);

    localparam logic [RETRY_W-1:0] c_RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
    localparam logic [BO_W-1:0]    c_BO_INIT    = BO_W'(RETRY_WAIT);
    localparam logic [BO_W-1:0]    c_BO_ONE     = BO_W'(1);
    localparam logic [TO_W-1:0]    c_TO_LAST    = TO_W'(S1_TIMEOUT - 1);

    snoop_req_state_t   r_state;
    snoop_req_state_t   w_state_nxt;

    logic [PADDR_W-1:0] r_paddr;
    logic [RETRY_W-1:0] r_retry_cnt;
    logic [BO_W-1:0]    r_backoff;
    logic [TO_W-1:0]    r_to_cnt;
    snoop_resp_status_t r_status;
    logic [DATA_W-1:0]  r_data;
    logic [BE_W-1:0]    r_be;

    // Decoded s1 events, only meaningful while in S1
    logic w_s1_conflict;
    logic w_retry_last;
    logic w_to_expire;

    assign w_s1_conflict = i_l1d_resp_s1_valid &&
                           (i_l1d_resp_s1_status == STATUS_L1D_CONFLICT);
    assign w_retry_last  = (r_retry_cnt == c_RETRY_LAST);
    assign w_to_expire   = !i_l1d_resp_s1_valid && (r_to_cnt == c_TO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_snoop_req_valid) begin
                    w_state_nxt = ST_S0;
                end
            end
            ST_S0: begin
                w_state_nxt = ST_S1;
            end
            ST_S1: begin
                if (i_l1d_resp_s1_valid) begin
                    if (w_s1_conflict && !w_retry_last) begin
                        w_state_nxt = ST_BACKOFF;
                    end else begin
                        w_state_nxt = ST_RESP;
                    end
                end else if (w_to_expire) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_BACKOFF: begin
                if (r_backoff == c_BO_ONE) begin
                    w_state_nxt = ST_S0;
                end
            end
            ST_RESP: begin
                if (i_snoop_resp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (Moore, decoded from the state register)
    // ------------------------------------------------------------------
    always_comb begin
        o_snoop_req_ready  = 1'b0;
        o_l1d_req_s0_valid = 1'b0;
        o_snoop_resp_valid = 1'b0;
        o_busy             = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_snoop_req_ready = 1'b1;
                o_busy            = 1'b0;
            end
            ST_S0:   o_l1d_req_s0_valid = 1'b1;
            ST_RESP: o_snoop_resp_valid = 1'b1;
            default: begin
            end
        endcase
    end

    assign o_l1d_req_s0_paddr  = r_paddr;
    assign o_snoop_resp_status = r_status;
    assign o_snoop_resp_data   = r_data;
    assign o_snoop_resp_be     = r_be;

    // ------------------------------------------------------------------
    // Address latch, counters and response payload
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_paddr     <= '0;
            r_retry_cnt <= '0;
            r_backoff   <= '0;
            r_to_cnt    <= '0;
            r_status    <= SNOOP_HIT;
            r_data      <= '0;
            r_be        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_snoop_req_valid) begin
                        r_paddr     <= i_snoop_req_paddr;
                        r_retry_cnt <= '0;
                    end
                end
                ST_S0: begin
                    r_to_cnt <= '0;
                end
                ST_S1: begin
                    if (i_l1d_resp_s1_valid) begin
                        if (i_l1d_resp_s1_status == STATUS_HIT) begin
                            r_status <= SNOOP_HIT;
                            r_data   <= i_l1d_resp_s1_data;
                            r_be     <= i_l1d_resp_s1_be;
                        end else if (w_s1_conflict) begin
                            if (w_retry_last) begin
                                r_status <= SNOOP_RETRY_FAIL;
                                r_data   <= '0;
                                r_be     <= '0;
                            end else begin
                                r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                                r_backoff   <= c_BO_INIT;
                            end
                        end else begin
                            // NONE is reported as a miss
                            r_status <= SNOOP_MISS;
                            r_data   <= '0;
                            r_be     <= '0;
                        end
                    end else if (w_to_expire) begin
                        r_status <= SNOOP_TIMEOUT;
                        r_data   <= '0;
                        r_be     <= '0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_BACKOFF: begin
                    // Leaves BACKOFF when the count reaches 1, so it never wraps
                    r_backoff <= r_backoff - BO_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scariv_l1d_snoop_requester.sv
// ============================================================================
// Module  : tb_scariv_l1d_snoop_requester
// Purpose : Self-checking bench for scariv_l1d_snoop_requester. A vector
//           table drives requests and configures an L1D responder model;
//           expected responses are queued at request time and compared when
//           the DUT presents them. Reset-in-backoff is a hand sequence.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scariv_l1d_snoop_requester;
    import scariv_l1d_snoop_requester_pkg::*;

    localparam int PADDR_W = 56;
    localparam int DATA_W  = 128;
    localparam int BE_W    = DATA_W / 8;

    logic                i_clk;
    logic                i_reset_n;
    logic                i_snoop_req_valid;
    logic                o_snoop_req_ready;
    logic [PADDR_W-1:0]  i_snoop_req_paddr;
    logic                o_l1d_req_s0_valid;
    logic [PADDR_W-1:0]  o_l1d_req_s0_paddr;
    logic                i_l1d_resp_s1_valid;
    lsu_status_t         i_l1d_resp_s1_status;
    logic [DATA_W-1:0]   i_l1d_resp_s1_data;
    logic [BE_W-1:0]     i_l1d_resp_s1_be;
    logic                o_snoop_resp_valid;
    logic                i_snoop_resp_ready;
    snoop_resp_status_t  o_snoop_resp_status;
    logic [DATA_W-1:0]   o_snoop_resp_data;
    logic [BE_W-1:0]     o_snoop_resp_be;
    logic                o_busy;

    scariv_l1d_snoop_requester #(
        .PADDR_W    (PADDR_W),
        .DATA_W     (DATA_W),
        .RETRY_WAIT (4),
        .MAX_RETRY  (8),
        .S1_TIMEOUT (15)
    ) u_dut (
        .i_clk                (i_clk),
        .i_reset_n            (i_reset_n),
        .i_snoop_req_valid    (i_snoop_req_valid),
        .o_snoop_req_ready    (o_snoop_req_ready),
        .i_snoop_req_paddr    (i_snoop_req_paddr),
        .o_l1d_req_s0_valid   (o_l1d_req_s0_valid),
        .o_l1d_req_s0_paddr   (o_l1d_req_s0_paddr),
        .i_l1d_resp_s1_valid  (i_l1d_resp_s1_valid),
        .i_l1d_resp_s1_status (i_l1d_resp_s1_status),
        .i_l1d_resp_s1_data   (i_l1d_resp_s1_data),
        .i_l1d_resp_s1_be     (i_l1d_resp_s1_be),
        .o_snoop_resp_valid   (o_snoop_resp_valid),
        .i_snoop_resp_ready   (i_snoop_resp_ready),
        .o_snoop_resp_status  (o_snoop_resp_status),
        .o_snoop_resp_data    (o_snoop_resp_data),
        .o_snoop_resp_be      (o_snoop_resp_be),
        .o_busy               (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- L1D responder model ----------------
    int                 rsp_conf   = 0;
    lsu_status_t        rsp_final  = STATUS_NONE;
    logic [DATA_W-1:0]  rsp_data   = '0;
    logic [BE_W-1:0]    rsp_be     = '0;
    bit                 rsp_silent = 1'b0;
    logic [PADDR_W-1:0] cur_paddr  = '0;
    int                 s0_cnt     = 0;
    int                 s0_cyc[$];

    initial begin
        i_l1d_resp_s1_valid  = 1'b0;
        i_l1d_resp_s1_status = STATUS_NONE;
        i_l1d_resp_s1_data   = '0;
        i_l1d_resp_s1_be     = '0;
        forever begin
            @(negedge i_clk);
            if (o_l1d_req_s0_valid) begin
                s0_cnt++;
                s0_cyc.push_back(cyc);
                chk("s0_paddr", DATA_W'(o_l1d_req_s0_paddr), DATA_W'(cur_paddr));
                if (!rsp_silent) begin
                    @(posedge i_clk);
                    #1;
                    i_l1d_resp_s1_valid = 1'b1;
                    if (rsp_conf > 0) begin
                        rsp_conf--;
                        i_l1d_resp_s1_status = STATUS_L1D_CONFLICT;
                        i_l1d_resp_s1_data   = '1;
                        i_l1d_resp_s1_be     = '1;
                    end else begin
                        i_l1d_resp_s1_status = rsp_final;
                        i_l1d_resp_s1_data   = rsp_data;
                        i_l1d_resp_s1_be     = rsp_be;
                    end
                    @(posedge i_clk);
                    #1;
                    i_l1d_resp_s1_valid  = 1'b0;
                    i_l1d_resp_s1_status = STATUS_NONE;
                    i_l1d_resp_s1_data   = '0;
                    i_l1d_resp_s1_be     = '0;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        snoop_resp_status_t st;
        logic [DATA_W-1:0]  data;
        logic [BE_W-1:0]    be;
        int                 lat;
        int                 n_s0;
        int                 hs_cyc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [PADDR_W-1:0] paddr;
        int                 n_conf;
        lsu_status_t        final_st;
        logic [DATA_W-1:0]  data;
        logic [BE_W-1:0]    be;
        bit                 silent;
        int                 hold;
        snoop_resp_status_t exp_st;
        logic [DATA_W-1:0]  exp_data;
        logic [BE_W-1:0]    exp_be;
        int                 exp_lat;
        int                 exp_s0;
    } vec_t;

    vec_t vecs[6];

    task automatic do_req(input string tag, input vec_t v);
        exp_t e;
        rsp_conf   = v.n_conf;
        rsp_final  = v.final_st;
        rsp_data   = v.data;
        rsp_be     = v.be;
        rsp_silent = v.silent;
        cur_paddr  = v.paddr;
        s0_cnt     = 0;
        s0_cyc.delete();
        @(posedge i_clk);
        #1;
        i_snoop_req_valid = 1'b1;
        i_snoop_req_paddr = v.paddr;
        @(negedge i_clk);
        chk({tag, "_req_ready"}, DATA_W'(o_snoop_req_ready), DATA_W'(1));
        @(posedge i_clk);
        #1;
        i_snoop_req_valid = 1'b0;
        e.st     = v.exp_st;
        e.data   = v.exp_data;
        e.be     = v.exp_be;
        e.lat    = v.exp_lat;
        e.n_s0   = v.exp_s0;
        e.hs_cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic collect(input string tag, input int hold);
        exp_t e;
        int   n;
        bit   got;
        e   = sb.pop_front();
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge i_clk);
            if (o_snoop_resp_valid) got = 1'b1;
            else n++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_resp_wait: got no response expected resp_valid within 400 cycles", tag);
            return;
        end
        chk({tag, "_latency"}, DATA_W'(cyc - e.hs_cyc), DATA_W'(e.lat));
        chk({tag, "_status"}, DATA_W'(o_snoop_resp_status), DATA_W'(e.st));
        chk({tag, "_data"}, o_snoop_resp_data, e.data);
        chk({tag, "_be"}, DATA_W'(o_snoop_resp_be), DATA_W'(e.be));
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            chk({tag, "_hold_valid"}, DATA_W'(o_snoop_resp_valid), DATA_W'(1));
            chk({tag, "_hold_status"}, DATA_W'(o_snoop_resp_status), DATA_W'(e.st));
            chk({tag, "_hold_data"}, o_snoop_resp_data, e.data);
            chk({tag, "_hold_be"}, DATA_W'(o_snoop_resp_be), DATA_W'(e.be));
        end
        i_snoop_resp_ready = 1'b1;
        @(posedge i_clk);
        #1;
        i_snoop_resp_ready = 1'b0;
        @(negedge i_clk);
        chk({tag, "_post_req_ready"}, DATA_W'(o_snoop_req_ready), DATA_W'(1));
        chk({tag, "_post_busy"}, DATA_W'(o_busy), DATA_W'(0));
        chk({tag, "_post_resp_valid"}, DATA_W'(o_snoop_resp_valid), DATA_W'(0));
        chk({tag, "_s0_count"}, DATA_W'(s0_cnt), DATA_W'(e.n_s0));
        // conflict at pulse+1, RETRY_WAIT=4 backoff, re-issue 5 cycles later
        for (int k = 1; k < s0_cyc.size(); k++) begin
            chk({tag, "_s0_spacing"}, DATA_W'(s0_cyc[k] - s0_cyc[k-1]), DATA_W'(6));
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, DATA_W'(o_snoop_req_ready), DATA_W'(1));
        chk({tag, "_s0_valid"}, DATA_W'(o_l1d_req_s0_valid), DATA_W'(0));
        chk({tag, "_s0_paddr"}, DATA_W'(o_l1d_req_s0_paddr), DATA_W'(0));
        chk({tag, "_resp_valid"}, DATA_W'(o_snoop_resp_valid), DATA_W'(0));
        chk({tag, "_resp_status"}, DATA_W'(o_snoop_resp_status), DATA_W'(0));
        chk({tag, "_resp_data"}, o_snoop_resp_data, DATA_W'(0));
        chk({tag, "_resp_be"}, DATA_W'(o_snoop_resp_be), DATA_W'(0));
        chk({tag, "_busy"}, DATA_W'(o_busy), DATA_W'(0));
    endtask

    initial begin
        vec_t v;
        bit   seen;
        logic [DATA_W-1:0] pat_a5;
        logic [DATA_W-1:0] pat_5a;
        pat_a5 = {16{8'hA5}};
        pat_5a = {8{16'h5AC3}};

        //          paddr              conf final                data                      be          sil hold exp_st            exp_data exp_be      lat s0
        vecs[0] = '{56'h0000_8000_1040, 0, STATUS_HIT,          pat_a5,                   {BE_W{1'b1}}, 0, 0, SNOOP_HIT,        pat_a5,  {BE_W{1'b1}}, 2,  1};
        vecs[1] = '{56'h0000_8000_2080, 0, STATUS_MISS,         {4{32'hDEAD_BEEF}},       16'hF0F0,     0, 5, SNOOP_MISS,       '0,      '0,           2,  1};
        vecs[2] = '{56'h00AB_1234_5678, 0, STATUS_NONE,         {4{32'h1357_9BDF}},       16'h0F0F,     0, 0, SNOOP_MISS,       '0,      '0,           2,  1};
        vecs[3] = '{56'h0000_8000_30C0, 2, STATUS_HIT,          pat_5a,                   16'h00FF,     0, 0, SNOOP_HIT,        pat_5a,  16'h00FF,     14, 3};
        vecs[4] = '{56'h0000_8000_4100, 8, STATUS_HIT,          pat_a5,                   {BE_W{1'b1}}, 0, 0, SNOOP_RETRY_FAIL, '0,      '0,           44, 8};
        vecs[5] = '{56'h0000_8000_5140, 0, STATUS_HIT,          pat_a5,                   {BE_W{1'b1}}, 1, 0, SNOOP_TIMEOUT,    '0,      '0,           16, 1};

        i_reset_n          = 1'b0;
        i_snoop_req_valid  = 1'b0;
        i_snoop_req_paddr  = '0;
        i_snoop_resp_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_reset_outputs("reset");
        i_reset_n = 1'b1;
        repeat (2) @(negedge i_clk);
        chk_reset_outputs("after_reset");

        for (int i = 0; i < 6; i++) begin
            do_req($sformatf("v%0d", i), vecs[i]);
            collect($sformatf("v%0d", i), vecs[i].hold);
        end

        // Reset while in BACKOFF: no s0 or response may follow
        v        = vecs[0];
        v.n_conf = 100;
        do_req("rst_bo", v);
        void'(sb.pop_front());
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk("rst_bo_busy", DATA_W'(o_busy), DATA_W'(1));
        chk("rst_bo_s0_count", DATA_W'(s0_cnt), DATA_W'(1));
        chk("rst_bo_s0_low", DATA_W'(o_l1d_req_s0_valid), DATA_W'(0));
        #1;
        i_reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_bo_in_reset");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        rsp_conf  = 0;
        s0_cnt    = 0;
        seen      = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_l1d_req_s0_valid || o_snoop_resp_valid || o_busy) seen = 1'b1;
        end
        chk("rst_bo_quiet", DATA_W'(seen), DATA_W'(0));
        chk_reset_outputs("rst_bo_after");

        v       = vecs[0];
        v.paddr = 56'h0000_8000_6180;
        do_req("post_rst", v);
        collect("post_rst", 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/scariv_l1d_snoop_requester.md
Name: scariv_l1d_snoop_requester

Overview:
Initiator side of the L1D snoop port: accepts coherence snoop requests (physical address) from the L2/coherence fabric, drives the LSU L1D snoop read port, and collects the s1 response. On L1D_CONFLICT it backs off and retries up to a limit. It returns hit/miss, data and byte-enables to the requester over a valid/ready response channel. Sits between the coherence agent and the LSU top's L1D snoop slave.

Parameters:
PADDR_W, riscv_pkg::PADDR_W, physical address width
DATA_W, scariv_conf_pkg::DCACHE_DATA_W, snoop data width
RETRY_WAIT, 4, backoff cycles after a conflict (>=1)
MAX_RETRY, 8, conflict retries before giving up (>=1)
S1_TIMEOUT, 15, cycles to wait for resp_s1_valid before error

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_snoop_req_valid  in  1  snoop request valid
o_snoop_req_ready  out  1  request accepted when valid&ready
i_snoop_req_paddr  in  PADDR_W  snoop address
o_l1d_req_s0_valid  out  1  L1D snoop port s0 request
o_l1d_req_s0_paddr  out  PADDR_W  s0 address
i_l1d_resp_s1_valid  in  1  L1D s1 response valid
i_l1d_resp_s1_status  in  lsu_status_t  NONE/HIT/MISS/L1D_CONFLICT
i_l1d_resp_s1_data  in  DATA_W  line data
i_l1d_resp_s1_be  in  DATA_W/8  byte enables
o_snoop_resp_valid  out  1  response valid
i_snoop_resp_ready  in  1  response consumed when valid&ready
o_snoop_resp_status  out  snoop_resp_status_t  HIT/MISS/RETRY_FAIL/TIMEOUT
o_snoop_resp_data  out  DATA_W  captured data (0 unless HIT)
o_snoop_resp_be  out  DATA_W/8  captured be (0 unless HIT)
o_busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except o_snoop_req_ready=1; address/data/be regs, counters 0. Reset mid-transaction aborts silently, no response.
- States: IDLE, S0, S1, BACKOFF, RESP.
- IDLE: ready=1. On valid&ready: latch paddr, clear retry count -> S0.
- S0: o_l1d_req_s0_valid=1 for exactly one cycle with latched paddr -> S1; timeout counter cleared.
- S1: wait for i_l1d_resp_s1_valid (nominally the next cycle).
  - HIT: capture data/be, status HIT -> RESP.
  - MISS or NONE: data/be=0, status MISS -> RESP.
  - L1D_CONFLICT: if retry_cnt==MAX_RETRY-1, status RETRY_FAIL -> RESP; else retry_cnt++, load backoff=RETRY_WAIT -> BACKOFF.
  - No valid response within S1_TIMEOUT cycles: status TIMEOUT -> RESP.
- BACKOFF: decrement each cycle; at 1 -> S0. So re-issue occurs RETRY_WAIT+1 cycles after the conflict response.
- RESP: o_snoop_resp_valid=1; payload stable until handshake. On ready -> IDLE. ready=0 in all non-IDLE states; there is no request/response overlap. The next request is accepted at the earliest one cycle after the handshake.
- i_l1d_resp_s1_valid outside S1 is ignored.
- Best-case latency: request handshake at cycle 0, s0 at cycle 1, s1 at cycle 2, resp_valid at cycle 3.
- Counters are sized $clog2(max+1) and must not wrap.

Decomposition:
- scariv_lsu_pkg: snoop_resp_status_t (2-bit enum HIT=0, MISS=1, RETRY_FAIL=2, TIMEOUT=3) and snoop_req_state_t. lsu_status_t is reused unchanged.
- No sub-module; one FSM with retry/backoff/timeout counters.

Test Plan:
- Req paddr=0x8000_1040; s1 HIT at cycle 2, data=0xA5.. pattern, be=all ones -> resp at cycle 3, status HIT, data/be match, s0 paddr=0x8000_1040.
- s1 MISS -> status MISS, data=0, be=0; resp held 5 cycles with ready=0 and payload stable; ready=1 -> IDLE, req_ready=1 the next cycle.
- Two CONFLICTs, then HIT -> exactly three s0 pulses, each 5 cycles after the preceding conflict; status HIT.
- CONFLICT on every attempt, MAX_RETRY=8 -> exactly 8 s0 pulses, status RETRY_FAIL.
- No s1 response -> after 15 cycles in S1, status TIMEOUT.
- Reset asserted in BACKOFF -> all outputs at reset values, no s0 or resp afterwards; a new request then completes normally.
